// File: rtl/burst_mem_ctrl.sv
// Cacheline burst controller: turns held read/write burst requests into
// per-beat accesses on a single-port backing RAM with fixed read latency.
module burst_mem_ctrl #(
  parameter int BEATS   = 4,
  parameter int RAM_LAT = 2,
  parameter int RAM_AW  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [63:0]       mem_wdata,
  output logic [63:0]       mem_rdata,
  output logic              mem_resp,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [63:0]       ram_wdata,
  input  logic [63:0]       ram_rdata,
  output logic              busy
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_DRAIN, DONE} state_t;

  state_t             state_reg;
  logic [RAM_AW-1:0]  base_reg;
  logic [CW-1:0]      wbeat_reg;
  logic [CW-1:0]      ibeat_reg;
  logic [CW-1:0]      rbeat_reg;
  logic [RAM_LAT-1:0] vld_reg;

  logic [RAM_AW-1:0]  base_calc;
  logic               rd_strobe;
  logic               vld_out;
  logic               unused_addr_bits;

  // Line index scaled to a word address; the product wraps modulo 2^RAM_AW.
  assign base_calc        = RAM_AW'(mem_address[RAM_AW+2:5]) * RAM_AW'(BEATS);
  assign unused_addr_bits = ^{mem_address[31:RAM_AW+3], mem_address[4:0]};
  assign rd_strobe        = (state_reg == RD_ISSUE);
  assign vld_out          = vld_reg[RAM_LAT-1];
  assign busy             = (state_reg != IDLE);

  // One valid bit per issued read, aligned with ram_rdata at the tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_reg <= '0;
    end else begin
      vld_reg[0] <= rd_strobe;
      for (int i = 1; i < RAM_LAT; i++) vld_reg[i] <= vld_reg[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      base_reg  <= '0;
      wbeat_reg <= '0;
      ibeat_reg <= '0;
      rbeat_reg <= '0;
    end else begin
      if (vld_out) rbeat_reg <= (rbeat_reg == LAST_BEAT) ? '0 : rbeat_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          if (mem_read) begin
            base_reg  <= base_calc;
            state_reg <= RD_ISSUE;
          end else if (mem_write) begin
            base_reg  <= base_calc;
            state_reg <= WR;
          end
        end
        WR: begin
          if (wbeat_reg == LAST_BEAT) begin
            wbeat_reg <= '0;
            state_reg <= DONE;
          end else begin
            wbeat_reg <= wbeat_reg + 1'b1;
          end
        end
        RD_ISSUE: begin
          if (ibeat_reg == LAST_BEAT) begin
            ibeat_reg <= '0;
            state_reg <= RD_DRAIN;
          end else begin
            ibeat_reg <= ibeat_reg + 1'b1;
          end
        end
        RD_DRAIN: begin
          // The last read response always lands here, since RAM_LAT >= 1.
          if (vld_out && rbeat_reg == LAST_BEAT) state_reg <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Beat outputs decode from state so beat 0 goes out in the first burst cycle.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    case (state_reg)
      WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = base_reg + RAM_AW'(wbeat_reg);
        ram_wdata = mem_wdata;
        mem_resp  = 1'b1;
      end
      RD_ISSUE: begin
        ram_en   = 1'b1;
        ram_addr = base_reg + RAM_AW'(ibeat_reg);
      end
      default: ;
    endcase
    if (vld_out) begin
      mem_resp  = 1'b1;
      mem_rdata = ram_rdata;
    end
  end

endmodule

// File: tb/tb_burst_mem_ctrl.sv
// Directed bench for burst_mem_ctrl: behavioural RAM with RAM_LAT read latency
// and per-cycle expectations for write, read, wrap, collision and reset cases.
module tb_burst_mem_ctrl;

  localparam int BEATS   = 4;
  localparam int RAM_LAT = 2;
  localparam int RAM_AW  = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [31:0]       mem_address = '0;
  logic              mem_read = 1'b0;
  logic              mem_write = 1'b0;
  logic [63:0]       mem_wdata = '0;
  logic [63:0]       mem_rdata;
  logic              mem_resp;
  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [63:0]       ram_wdata;
  logic [63:0]       ram_rdata;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [63:0] ram_mem [0:(1<<RAM_AW)-1];
  logic [63:0] rd_pipe [0:RAM_LAT-1];

  burst_mem_ctrl #(.BEATS(BEATS), .RAM_LAT(RAM_LAT), .RAM_AW(RAM_AW)) dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Backing RAM: data for a read strobe appears RAM_LAT cycles later.
  always @(posedge clk) begin
    if (ram_en && ram_we) ram_mem[ram_addr] <= ram_wdata;
    rd_pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr] : 64'h0;
    for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[RAM_LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called just after the edge that opens cycle 0; returns at the start of cycle 6.
  task automatic run_write(input logic [31:0] addr, input logic [RAM_AW-1:0] base,
                           input logic [63:0] d0, input logic [63:0] d1,
                           input logic [63:0] d2, input logic [63:0] d3);
    logic [63:0] d [4];
    bit act;
    d = '{d0, d1, d2, d3};
    mem_address = addr;
    mem_write   = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      act = (c >= 1 && c <= 4);
      if (act) mem_wdata = d[c-1];
      @(negedge clk);
      check($sformatf("wr c%0d ram_en", c), 64'(ram_en), 64'(act));
      check($sformatf("wr c%0d ram_we", c), 64'(ram_we), 64'(act));
      check($sformatf("wr c%0d ram_addr", c), 64'(ram_addr), act ? 64'(base + RAM_AW'(c-1)) : 64'h0);
      check($sformatf("wr c%0d ram_wdata", c), ram_wdata, act ? d[c-1] : 64'h0);
      check($sformatf("wr c%0d mem_resp", c), 64'(mem_resp), 64'(act));
      check($sformatf("wr c%0d busy", c), 64'(busy), 64'(c >= 1));
      $display("wr cycle %0d addr=%h en=%b we=%b resp=%b busy=%b", c, ram_addr, ram_en, ram_we, mem_resp, busy);
      @(posedge clk); #1;
      if (c == 4) mem_write = 1'b0;
    end
  endtask

  // Same entry convention; returns at the start of cycle 8 (first IDLE cycle).
  task automatic run_read(input logic [31:0] addr, input logic [RAM_AW-1:0] base, input bit also_write,
                          input logic [63:0] d0, input logic [63:0] d1,
                          input logic [63:0] d2, input logic [63:0] d3);
    logic [63:0] d [4];
    bit iss, rsp;
    d = '{d0, d1, d2, d3};
    mem_address = addr;
    mem_read    = 1'b1;
    mem_write   = also_write;
    mem_wdata   = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int c = 0; c <= 7; c++) begin
      iss = (c >= 1 && c <= 4);
      rsp = (c >= 3 && c <= 6);
      @(negedge clk);
      check($sformatf("rd c%0d ram_en", c), 64'(ram_en), 64'(iss));
      check($sformatf("rd c%0d ram_we", c), 64'(ram_we), 64'h0);
      check($sformatf("rd c%0d ram_addr", c), 64'(ram_addr), iss ? 64'(base + RAM_AW'(c-1)) : 64'h0);
      check($sformatf("rd c%0d mem_resp", c), 64'(mem_resp), 64'(rsp));
      check($sformatf("rd c%0d mem_rdata", c), mem_rdata, rsp ? d[c-3] : 64'h0);
      check($sformatf("rd c%0d busy", c), 64'(busy), 64'(c >= 1));
      $display("rd cycle %0d addr=%h en=%b resp=%b rdata=%h busy=%b", c, ram_addr, ram_en, mem_resp, mem_rdata, busy);
      @(posedge clk); #1;
      if (c == 6) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check($sformatf("%s c%0d mem_resp", tag, c), 64'(mem_resp), 64'h0);
      check($sformatf("%s c%0d busy", tag, c), 64'(busy), 64'h0);
      check($sformatf("%s c%0d ram_en", tag, c), 64'(ram_en), 64'h0);
      $display("%s cycle %0d resp=%b busy=%b en=%b", tag, c, mem_resp, busy, ram_en);
      @(posedge clk); #1;
    end
  endtask

  localparam logic [63:0] D1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] D4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] E1 = 64'hA0A0_0000_0000_03FC;
  localparam logic [63:0] E2 = 64'hA1A1_0000_0000_03FD;
  localparam logic [63:0] E3 = 64'hA2A2_0000_0000_03FE;
  localparam logic [63:0] E4 = 64'hA3A3_0000_0000_03FF;

  initial begin
    // Outputs while reset is held
    #12;
    check("rst busy", 64'(busy), 64'h0);
    check("rst ram_en", 64'(ram_en), 64'h0);
    check("rst mem_resp", 64'(mem_resp), 64'h0);
    check("rst ram_addr", 64'(ram_addr), 64'h0);
    $display("reset held busy=%b en=%b resp=%b", busy, ram_en, mem_resp);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Write line 0x40, then read it back with only the DONE + IDLE gap
    run_write(32'h0000_0040, 10'd8, D1, D2, D3, D4);
    run_read(32'h0000_0040, 10'd8, 1'b0, D1, D2, D3, D4);

    // Top-of-RAM line; readback with both requests high must stay a read
    run_write(32'h0000_7FE0, 10'h3FC, E1, E2, E3, E4);
    run_read(32'h0000_7FE0, 10'h3FC, 1'b1, E1, E2, E3, E4);
    idle_cycles("idle", 2);

    // Counters must restart from base after the wrapping burst
    run_read(32'h0000_0040, 10'd8, 1'b0, D1, D2, D3, D4);

    // Reset in cycle 4 of a read burst
    mem_address = 32'h0000_0040;
    mem_read    = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("pre-rst mem_resp", 64'(mem_resp), 64'h1);
    #2;
    mem_read = 1'b0;
    rst      = 1'b0;
    #1;
    check("midrst mem_resp", 64'(mem_resp), 64'h0);
    check("midrst busy", 64'(busy), 64'h0);
    check("midrst ram_en", 64'(ram_en), 64'h0);
    check("midrst mem_rdata", mem_rdata, 64'h0);
    $display("mid-burst reset resp=%b busy=%b en=%b", mem_resp, busy, ram_en);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    idle_cycles("post-rst", 10);

    run_read(32'h0000_0040, 10'd8, 1'b0, D1, D2, D3, D4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_mem_ctrl.md
BURST_MEM_CTRL -- requirements
Module: burst_mem_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- BEATS, 4, 64-bit beats per cacheline burst.
- RAM_LAT, 2, backing-RAM read latency in cycles (range 1-4).
- RAM_AW, 10, backing-RAM word-address width.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_address  in  32  burst base byte address; bits [4:0] ignored.
- mem_read  in  1  burst read request, held until the final mem_resp.
- mem_write  in  1  burst write request, held until the final mem_resp.
- mem_wdata  in  64  current write beat.
- mem_rdata  out  64  current read beat.
- mem_resp  out  1  one-cycle pulse per completed beat.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write strobe, qualified by ram_en.
- ram_addr  out  RAM_AW  RAM 64-bit word address.
- ram_wdata  out  64  RAM write data.
- ram_rdata  in  64  RAM read data, valid RAM_LAT cycles after a read strobe.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-003 FSM states SHALL be IDLE, WR, RD_ISSUE, RD_DRAIN and DONE.
REQ-004 In IDLE with mem_read=1, the block SHALL latch word base = mem_address[RAM_AW+2:5]*BEATS and enter RD_ISSUE.
REQ-005 In IDLE with mem_write=1 and mem_read=0, the block SHALL latch the base the same way and enter WR.
REQ-006 When mem_read and mem_write are both high in IDLE, read SHALL win; the write request is ignored.
REQ-007 WR: each cycle SHALL drive ram_en=1, ram_we=1, ram_addr=base+wbeat, ram_wdata=mem_wdata and mem_resp=1, then increment wbeat.
- Exit: after beat BEATS-1, go to DONE.
- Upstream presents beat 0 on entry to WR and beat k+1 in the cycle after the mem_resp for beat k.
REQ-008 RD_ISSUE: each cycle SHALL drive ram_en=1, ram_we=0, ram_addr=base+ibeat, then increment ibeat.
- Exit: after beat BEATS-1, go to RD_DRAIN.
REQ-009 A RAM_LAT-deep valid shift register SHALL track each read strobe; when its output is high, mem_resp=1 and mem_rdata=ram_rdata.
REQ-010 RD_DRAIN SHALL hold until rbeat (count of read responses) reaches BEATS, then go to DONE.
REQ-011 DONE SHALL last exactly one cycle with mem_resp=0 and requests ignored, then go to IDLE.
- Consequence: back-to-back bursts have one idle gap plus one IDLE decode cycle.
REQ-012 Read latency SHALL be: request sampled in IDLE at cycle 0, beat k mem_resp at cycle 1+k+RAM_LAT.
REQ-013 Write latency SHALL be: beat k mem_resp at cycle 1+k.
REQ-014 Beat counters SHALL be clog2(BEATS) bits wide and wrap to 0 on burst completion.
REQ-015 Word addresses SHALL be computed modulo 2^RAM_AW.
REQ-016 Requests dropped mid-burst SHALL NOT abort the burst; the burst completes, and for reads mem_resp pulses still occur.
REQ-017 mem_rdata SHALL equal 0 whenever mem_resp=0.
REQ-018 In IDLE and DONE, ram_en, ram_we and mem_resp SHALL all be 0.

Reset
REQ-019 rst=0 SHALL, immediately and asynchronously, force state=IDLE.
REQ-020 rst=0 SHALL clear all beat counters, the base register and the valid pipeline.
REQ-021 rst=0 SHALL drive mem_resp, ram_en, ram_we and busy to 0, and mem_rdata, ram_addr and ram_wdata to 0.
REQ-022 Reset asserted mid-burst SHALL discard in-flight read beats; no mem_resp SHALL appear after reset release until a new request.
REQ-023 The first request SHALL be sampled on the first rising edge with rst=1.

Verification
REQ-024 Write burst: mem_write=1, address 0x0000_0040, wdata beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
- Required: ram writes to words 8-11 on cycles 1-4, mem_resp high on cycles 1-4, busy low on cycle 6.
REQ-025 Read burst (RAM_LAT=2), address 0x0000_0040, RAM preloaded per REQ-024.
- Required: ram reads of words 8-11 on cycles 1-4, mem_resp high on cycles 3-6 with rdata 0x11..11 through 0x44..44, DONE on cycle 7.
REQ-026 Simultaneous mem_read=1 and mem_write=1 in IDLE.
- Required: read burst only, ram_we never asserted.
REQ-027 Reset pulse on cycle 4 of a read burst.
- Required: mem_resp=0, busy=0 and ram_en=0 immediately, and no mem_resp for 10 cycles after release with requests low.
REQ-028 Address wrap: address 0x0000_7FE0 with RAM_AW=10.
- Required: word addresses 0x3FC-0x3FF, with correct counter wrap to 0 at completion.
REQ-029 Back-to-back: a write burst followed by a read burst of the same line.
- Required: read beats return the written data, and exactly one DONE gap plus one IDLE cycle separate the bursts.
